// File: rtl/mips_exec_unit.sv
// mips_exec_unit: registered execute stage (ALU-control decode, 32-bit ALU, branch-target adder)
// Ports: i_clk, i_reset (async, active-high), i_en (capture enable), i_alu_op/i_funct/i_rt_field (op select),
//        i_a/i_b/i_shamt (operands), i_pc/i_imm16 (branch base/offset),
//        o_result, o_zero (result==0, 1 = branch taken), o_branch_target.
module mips_exec_unit (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_en,
   input  logic [3:0]  i_alu_op,
   input  logic [5:0]  i_funct,
   input  logic [4:0]  i_rt_field,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic [4:0]  i_shamt,
   input  logic [31:0] i_pc,
   input  logic [15:0] i_imm16,
   output logic [31:0] o_result,
   output logic        o_zero,
   output logic [31:0] o_branch_target
);
   typedef enum logic [4:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
      OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_LUI, OP_PASSA,
      OP_EQ, OP_NE, OP_LTZ, OP_GEZ, OP_GTZ, OP_LEZ
   } op_t;
   op_t         w_funct_op, w_regimm_op, w_op;
   logic [31:0] w_result, w_branch_target;
   always_comb begin
      w_funct_op = OP_ADD;
      case (i_funct)
         6'h00: w_funct_op = OP_SLL;
         6'h02: w_funct_op = OP_SRL;
         6'h03: w_funct_op = OP_SRA;
         6'h04: w_funct_op = OP_SLLV;
         6'h06: w_funct_op = OP_SRLV;
         6'h07: w_funct_op = OP_SRAV;
         6'h08, 6'h09: w_funct_op = OP_PASSA;
         6'h22, 6'h23: w_funct_op = OP_SUB;
         6'h24: w_funct_op = OP_AND;
         6'h25: w_funct_op = OP_OR;
         6'h26: w_funct_op = OP_XOR;
         6'h27: w_funct_op = OP_NOR;
         6'h2A: w_funct_op = OP_SLT;
         6'h2B: w_funct_op = OP_SLTU;
         default: w_funct_op = OP_ADD;
      endcase
   end
   // bltz/bltzal map to LTZ; everything else in REGIMM falls back to GEZ
   assign w_regimm_op = (i_rt_field == 5'd0 || i_rt_field == 5'd16) ? OP_LTZ : OP_GEZ;
   always_comb begin
      w_op = OP_ADD;
      case (i_alu_op)
         4'd1:  w_op = OP_EQ;
         4'd2:  w_op = w_funct_op;
         4'd3:  w_op = OP_AND;
         4'd4:  w_op = OP_OR;
         4'd5:  w_op = OP_XOR;
         4'd6:  w_op = OP_SLT;
         4'd7:  w_op = OP_SLTU;
         4'd8:  w_op = OP_NE;
         4'd9:  w_op = w_regimm_op;
         4'd10: w_op = OP_GTZ;
         4'd11: w_op = OP_LEZ;
         4'd12: w_op = OP_LUI;
         default: w_op = OP_ADD;
      endcase
   end
   // branch ops return 0 when taken so that zero doubles as the taken flag
   always_comb begin
      w_result = i_a + i_b;
      case (w_op)
         OP_SUB:   w_result = i_a - i_b;
         OP_AND:   w_result = i_a & i_b;
         OP_OR:    w_result = i_a | i_b;
         OP_XOR:   w_result = i_a ^ i_b;
         OP_NOR:   w_result = ~(i_a | i_b);
         OP_SLT:   w_result = {31'b0, $signed(i_a) < $signed(i_b)};
         OP_SLTU:  w_result = {31'b0, i_a < i_b};
         OP_SLL:   w_result = i_b << i_shamt;
         OP_SRL:   w_result = i_b >> i_shamt;
         OP_SRA:   w_result = $signed(i_b) >>> i_shamt;
         OP_SLLV:  w_result = i_b << i_a[4:0];
         OP_SRLV:  w_result = i_b >> i_a[4:0];
         OP_SRAV:  w_result = $signed(i_b) >>> i_a[4:0];
         OP_LUI:   w_result = {i_b[15:0], 16'h0};
         OP_PASSA: w_result = i_a;
         OP_EQ:    w_result = {31'b0, i_a != i_b};
         OP_NE:    w_result = {31'b0, i_a == i_b};
         OP_LTZ:   w_result = {31'b0, ~i_a[31]};
         OP_GEZ:   w_result = {31'b0, i_a[31]};
         OP_GTZ:   w_result = {31'b0, i_a[31] || i_a == 32'h0};
         OP_LEZ:   w_result = {31'b0, !(i_a[31] || i_a == 32'h0)};
         default:  w_result = i_a + i_b;
      endcase
   end
   assign w_branch_target = i_pc + {{14{i_imm16[15]}}, i_imm16, 2'b00};
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_result        <= 32'h0;
         o_zero          <= 1'b0;
         o_branch_target <= 32'h0;
      end else if (i_en) begin
         o_result        <= w_result;
         o_zero          <= (w_result == 32'h0);
         o_branch_target <= w_branch_target;
      end
   end
endmodule

// File: tb/tb_mips_exec_unit.sv
// tb_mips_exec_unit: directed plan plus randomized ops checked against a behavioural model
module tb_mips_exec_unit;
   logic        clk = 1'b0, reset = 1'b0, en = 1'b1;
   logic [3:0]  alu_op = '0;
   logic [5:0]  funct = '0;
   logic [4:0]  rt_field = '0, shamt = '0;
   logic [31:0] a = '0, b = '0, pc = '0;
   logic [15:0] imm16 = '0;
   logic [31:0] result, branch_target;
   logic        zero;
   int checks = 0, errors = 0;
   logic [31:0] e_res, e_bt;
   logic        e_zero;

   mips_exec_unit dut (
      .i_clk(clk), .i_reset(reset), .i_en(en), .i_alu_op(alu_op), .i_funct(funct),
      .i_rt_field(rt_field), .i_a(a), .i_b(b), .i_shamt(shamt), .i_pc(pc), .i_imm16(imm16),
      .o_result(result), .o_zero(zero), .o_branch_target(branch_target)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] taken(input bit c);
      return c ? 32'h0 : 32'h1;
   endfunction

   function automatic logic [31:0] model(input logic [3:0] op, input logic [5:0] f, input logic [4:0] rt,
                                         input logic [31:0] x, input logic [31:0] y, input logic [4:0] sh);
      int sx = $signed(x);
      int sy = $signed(y);
      logic [4:0] v = x[4:0];
      logic [31:0] fill_s = y[31] ? ~(32'hFFFFFFFF >> sh) : 32'h0;
      logic [31:0] fill_v = y[31] ? ~(32'hFFFFFFFF >> v) : 32'h0;
      case (op)
         4'd1:  return taken(x == y);
         4'd3:  return x & y;
         4'd4:  return x | y;
         4'd5:  return x ^ y;
         4'd6:  return (sx < sy) ? 32'd1 : 32'd0;
         4'd7:  return (x < y) ? 32'd1 : 32'd0;
         4'd8:  return taken(x != y);
         4'd9:  return (rt == 5'd0 || rt == 5'd16) ? taken(sx < 0) : taken(sx >= 0);
         4'd10: return taken(sx > 0);
         4'd11: return taken(sx <= 0);
         4'd12: return y * 32'h10000;
         4'd2: begin
            case (f)
               6'h00: return y * (32'd1 << sh);
               6'h02: return y / (32'd1 << sh);
               6'h03: return (y >> sh) | fill_s;
               6'h04: return y * (32'd1 << v);
               6'h06: return y / (32'd1 << v);
               6'h07: return (y >> v) | fill_v;
               6'h08, 6'h09: return x;
               6'h22, 6'h23: return x + (~y + 32'd1);
               6'h24: return x & y;
               6'h25: return x | y;
               6'h26: return x ^ y;
               6'h27: return ~(x | y);
               6'h2A: return (sx < sy) ? 32'd1 : 32'd0;
               6'h2B: return (x < y) ? 32'd1 : 32'd0;
               default: return x + y;
            endcase
         end
         default: return x + y;
      endcase
   endfunction

   initial begin
      logic [5:0] fl [0:19] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h20, 6'h21,
                                6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h01, 6'h3F};
      a = 1; b = 2; alu_op = 0; en = 1;
      step();
      chk("pre_reset_add", result, 32'd3);
      a = 5; b = 5; pc = 32'h100; imm16 = 16'h4;
      #2 reset = 1;
      #1;
      chk("reset_result", result, 32'h0);
      chk("reset_zero", {31'b0, zero}, 32'h0);
      chk("reset_bt", branch_target, 32'h0);
      step();
      chk("reset_held_result", result, 32'h0);
      reset = 0;
      step();
      chk("post_reset_result", result, 32'd10);
      chk("post_reset_zero", {31'b0, zero}, 32'h0);
      chk("post_reset_bt", branch_target, 32'h110);
      alu_op = 2; funct = 6'h23; a = 3; b = 5;
      step();
      chk("subu_result", result, 32'hFFFFFFFE);
      chk("subu_zero", {31'b0, zero}, 32'h0);
      funct = 6'h2A; a = 32'hFFFFFFFF; b = 1;
      step();
      chk("slt_result", result, 32'h1);
      funct = 6'h2B;
      step();
      chk("sltu_result", result, 32'h0);
      chk("sltu_zero", {31'b0, zero}, 32'h1);
      b = 32'h80000010; shamt = 4; funct = 6'h03;
      step();
      chk("sra_result", result, 32'hF8000001);
      funct = 6'h02;
      step();
      chk("srl_result", result, 32'h08000001);
      funct = 6'h04; a = 33;
      step();
      chk("sllv_result", result, 32'h00000020);
      alu_op = 1; a = 7; b = 7;
      step();
      chk("beq_zero", {31'b0, zero}, 32'h1);
      alu_op = 8;
      step();
      chk("bne_zero", {31'b0, zero}, 32'h0);
      alu_op = 9; rt_field = 5'd0; a = 32'h80000000;
      step();
      chk("bltz_zero", {31'b0, zero}, 32'h1);
      alu_op = 10; a = 0;
      step();
      chk("bgtz_zero", {31'b0, zero}, 32'h0);
      alu_op = 11;
      step();
      chk("blez_zero", {31'b0, zero}, 32'h1);
      pc = 32'hBFC00004; imm16 = 16'hFFFF;
      step();
      chk("bt_neg", branch_target, 32'hBFC00000);
      pc = 32'hFFFFFFFC; imm16 = 16'h0002;
      step();
      chk("bt_wrap", branch_target, 32'h00000004);
      alu_op = 12; b = 32'h00001234;
      step();
      chk("lui_result", result, 32'h12340000);
      en = 0;
      for (int i = 0; i < 3; i++) begin
         alu_op = 4'($urandom); funct = 6'($urandom); a = $urandom; b = $urandom;
         pc = $urandom; imm16 = 16'($urandom); shamt = 5'($urandom); rt_field = 5'($urandom);
         step();
         chk("hold_result", result, 32'h12340000);
         chk("hold_zero", {31'b0, zero}, 32'h0);
         chk("hold_bt", branch_target, 32'h00000004);
      end
      e_res = 32'h12340000; e_zero = 0; e_bt = 32'h4;
      for (int i = 0; i < 400; i++) begin
         alu_op = 4'($urandom);
         funct = fl[$urandom_range(0, 19)];
         rt_field = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 1) * 16) : 5'($urandom);
         case ($urandom_range(0, 3))
            0: a = 0;
            1: a = $urandom_range(0, 40);
            default: a = $urandom;
         endcase
         b = ($urandom_range(0, 4) == 0) ? a : $urandom;
         shamt = 5'($urandom); pc = $urandom; imm16 = 16'($urandom);
         en = ($urandom_range(0, 3) != 0);
         if (en) begin
            e_res = model(alu_op, funct, rt_field, a, b, shamt);
            e_zero = (e_res == 0);
            e_bt = pc + 32'($signed(imm16)) * 4;
         end
         step();
         chk("rand_result", result, e_res);
         chk("rand_zero", {31'b0, zero}, {31'b0, e_zero});
         chk("rand_bt", branch_target, e_bt);
      end
      en = 1;
      #2 reset = 1;
      #1;
      chk("midrun_reset_result", result, 32'h0);
      chk("midrun_reset_bt", branch_target, 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mips_exec_unit.md
# mips_exec_unit

Registered execute-stage arithmetic block for the multicycle MIPS core. It combines three functions: ALU-control decode (ALUOp/funct/rt to a 5-bit operation code), the 32-bit integer ALU with a zero/branch-condition flag, and the branch-target adder. It sits between the register file / immediate mux and the PC, memory-address and write-back muxes. All results are captured into one output register stage.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all output registers.
- en  in  1  capture enable for the output registers.
- alu_op  in  4  operation class from the control unit.
- funct  in  6  instr[5:0], decoded when alu_op=R-type.
- rt_field  in  5  instr[20:16], decoded when alu_op=REGIMM.
- a  in  32  operand A (rs data).
- b  in  32  operand B (rt data or extended immediate, already muxed).
- shamt  in  5  instr[10:6].
- pc  in  32  PC value used as branch base.
- imm16  in  16  instr[15:0].
- result  out  32  registered ALU result.
- zero  out  1  registered (result==0); for branch ops, 1 = branch taken.
- branch_target  out  32  registered pc + (sign_extend(imm16) << 2).

## Operation
The block computes everything combinationally and registers it when en=1.

alu_op decode (value -> op):
- 0 → ADD.
- 1 → EQ (beq).
- 2 → R-type, decoded from funct.
- 3 → AND.
- 4 → OR.
- 5 → XOR.
- 6 → SLT.
- 7 → SLTU.
- 8 → NE (bne).
- 9 → REGIMM, decoded from rt_field.
- 10 → GTZ.
- 11 → LEZ.
- 12 → LUI.
- 13–15 → ADD.

R-type funct decode (funct -> op):
- 0x00 → SLL; 0x02 → SRL; 0x03 → SRA.
- 0x04 → SLLV; 0x06 → SRLV; 0x07 → SRAV.
- 0x08/0x09 → PASSA (jr/jalr).
- 0x20/0x21 → ADD; 0x22/0x23 → SUB.
- 0x24 → AND; 0x25 → OR; 0x26 → XOR; 0x27 → NOR.
- 0x2A → SLT; 0x2B → SLTU.
- Any other funct → ADD.

REGIMM rt_field decode:
- 00000 / 10000 → LTZ.
- 00001 / 10001 → GEZ.
- Any other value → GEZ.

Op semantics (all arithmetic is modulo 2^32; no overflow traps or flags):
- ADD: a+b. SUB: a−b.
- AND, OR, XOR: bitwise. NOR: ~(a|b).
- SLT: {31'b0, signed(a)<signed(b)}. SLTU: unsigned compare, same format.
- SLL/SRL/SRA: shift b by shamt. SRA replicates b[31].
- SLLV/SRLV/SRAV: shift b by a[4:0].
- LUI: {b[15:0],16'h0}.
- PASSA: a.

Branch ops: result = 0 when the condition holds, 32'h1 otherwise.
- EQ: a==b.
- NE: a!=b.
- LTZ: signed a<0.
- GEZ: signed a>=0.
- GTZ: signed a>0.
- LEZ: signed a<=0.

Flags and adder:
- zero = (result==32'h0) for every op. Branch ops therefore give zero=1 exactly when the branch is taken.
- branch_target = pc + {{14{imm16[15]}}, imm16, 2'b00}, modulo 2^32. This is independent of alu_op.

## Timing
- Latency: 1 cycle. On the rising clk edge with en=1, result, zero and branch_target take the values computed from the inputs present before the edge.
- en=0: all outputs hold their previous value.
- reset asserted (asynchronous): result=0, zero=0, branch_target=0, immediately and for as long as reset is high. Reset overrides en. This includes a reset that arrives mid-sequence.
- The first capture after reset deasserts occurs on the first rising edge with reset=0 and en=1.
- No handshake; the block accepts a new operation every cycle.

## Test plan
- Reset: assert reset with en=1 and a=b=5, alu_op=0 → result=0, zero=0, branch_target=0 without a clock edge. After release and one edge → result=10, zero=0.
- ALU ops, alu_op=2:
  - funct 0x23, a=3, b=5 → result=32'hFFFFFFFE, zero=0.
  - funct 0x2A, a=32'hFFFFFFFF, b=1 → result=1.
  - funct 0x2B with the same operands → result=0, zero=1.
- Shifts, alu_op=2, b=32'h80000010:
  - funct 0x03, shamt=4 → result=32'hF8000001.
  - funct 0x02, shamt=4 → result=32'h08000001.
  - funct 0x04, a=33 → shift by 1 → result=32'h00000020.
- Branch conditions:
  - alu_op=1, a=b=7 → zero=1.
  - alu_op=8 with the same operands → zero=0.
  - alu_op=9, rt_field=00000, a=32'h80000000 → zero=1.
  - alu_op=10, a=0 → zero=0.
  - alu_op=11, a=0 → zero=1.
- Branch target:
  - pc=32'hBFC00004, imm16=16'hFFFF → branch_target=32'hBFC00000.
  - pc=32'hFFFFFFFC, imm16=16'h0002 → branch_target=32'h00000004 (wrap).
- Hold and LUI:
  - alu_op=12, b=32'h00001234 → result=32'h12340000.
  - Then set en=0 and change all inputs for 3 cycles → outputs unchanged.
